botoes_event_ctrl: RTL and testbench

Debounced, event-capturing controller for the board push-buttons, with an Avalon-MM slave interface. It is the sequencing layer between the raw 4-bit key inputs and the Nios II processor. It synchronises and debounces each key and latches press events into a write-1-to-clear capture register. It counts presses and raises a maskable interrupt, so software no longer polls raw key levels.

---
 rtl/botoes_event_ctrl_if.sv | 33 +++
 rtl/botoes_event_ctrl.sv | 166 ++++++++++++++++
 tb/tb_botoes_event_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/botoes_event_ctrl_if.sv
// ---------------------------------------------------------------------------
// botoes_event_ctrl_if
// Avalon-MM register bus shared between the Nios II side (master) and the
// push-button controller (slave).
//   address    : word select for the four controller registers
//   chipselect : slave select
//   write_n    : write strobe, active-low
//   writedata  : write data
//   readdata   : registered read data returned by the slave
// ---------------------------------------------------------------------------
interface botoes_event_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/botoes_event_ctrl.sv
// ---------------------------------------------------------------------------
// botoes_event_ctrl
// Synchronises and debounces the board push-buttons, captures press events in
// a write-1-to-clear register, counts presses and raises a maskable level
// interrupt so software does not need to poll raw key levels.
//
// Ports:
//   clk     : system clock
//   reset_n : asynchronous reset, active-low
//   bus     : Avalon-MM slave (address, chipselect, write_n, writedata,
//             readdata)
//   in_port : raw asynchronous button pins
//   irq     : interrupt request, level, active-high
//
// Register map (word addresses):
//   0 STATE (RO)   debounced key levels, 1 = pressed
//   1 EDGE  (W1C)  captured press events
//   2 MASK  (R/W)  interrupt enables
//   3 COUNT (R/W)  8-bit press counter, any write clears it
// ---------------------------------------------------------------------------
module botoes_event_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  botoes_event_ctrl_if.slave  bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic                irq
);

  localparam int              CW             = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST       = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RELEASED_LEVEL = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  localparam logic [1:0] ADDR_STATE = 2'd0;
  localparam logic [1:0] ADDR_EDGE  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  logic [WIDTH-1:0] syncMeta_q;
  logic [WIDTH-1:0] syncOut_q;
  logic [WIDTH-1:0] pressedSync;

  logic [CW-1:0]    debCnt_q [WIDTH];
  logic [CW-1:0]    debCnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;

  logic [WIDTH-1:0] pressEvent;
  logic             anyPress;

  logic [WIDTH-1:0] edgeCap_q;
  logic [WIDTH-1:0] edgeCap_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [7:0]       count_q;
  logic [7:0]       count_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;

  logic             wrEn;
  logic [WIDTH-1:0] w1cBits;
  logic             unusedWdata;

  // Only the low WIDTH bits of writedata carry information for any register.
  assign unusedWdata = ^bus.writedata[31:WIDTH];

  // Two-flop synchroniser on the raw pins. Reset loads the released pin level
  // so a key held through reset is seen as a fresh press once reset lifts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      syncMeta_q <= RELEASED_LEVEL;
      syncOut_q  <= RELEASED_LEVEL;
    end else begin
      syncMeta_q <= in_port;
      syncOut_q  <= syncMeta_q;
    end
  end

  assign pressedSync = syncOut_q ^ RELEASED_LEVEL;

  // Per-key debounce: the counter runs while the synchronised level disagrees
  // with the accepted level and the new level is accepted on the cycle the
  // counter would reach DEBOUNCE_CYCLES. Any agreement restarts the count, so
  // short glitches never reach the accepted level.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      debCnt_d[i] = '0;
      if (pressedSync[i] != stable_q[i]) begin
        if (debCnt_q[i] == CNT_LAST) begin
          stable_d[i] = pressedSync[i];
        end else begin
          debCnt_d[i] = debCnt_q[i] + CW'(1);
        end
      end
    end
  end

  // A press is the accepted level rising; it is visible in the same cycle the
  // level is accepted so EDGE/COUNT/irq move together with STATE.
  assign pressEvent = stable_d & ~stable_q;
  assign anyPress   = |pressEvent;
  assign wrEn       = bus.chipselect & ~bus.write_n;

  // Register next-state. A press on a bit being cleared wins over the clear,
  // and a COUNT write that coincides with a press leaves the count at 1 so
  // the press is not lost.
  always_comb begin
    w1cBits = '0;
    if (wrEn && (bus.address == ADDR_EDGE)) begin
      w1cBits = bus.writedata[WIDTH-1:0];
    end
    edgeCap_d = (edgeCap_q & ~w1cBits) | pressEvent;

    mask_d = mask_q;
    if (wrEn && (bus.address == ADDR_MASK)) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end

    if (wrEn && (bus.address == ADDR_COUNT)) begin
      count_d = {7'd0, anyPress};
    end else begin
      count_d = count_q + {7'd0, anyPress};
    end
  end

  // Read mux: readdata is refreshed every cycle from the addressed register,
  // matching the existing PIO slaves (one cycle latency, no side effects).
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_STATE: readdata_d[WIDTH-1:0] = stable_q;
      ADDR_EDGE:  readdata_d[WIDTH-1:0] = edgeCap_q;
      ADDR_MASK:  readdata_d[WIDTH-1:0] = mask_q;
      ADDR_COUNT: readdata_d[7:0]       = count_q;
    endcase
  end

  // State registers for debounce, capture, mask, counter and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        debCnt_q[i] <= '0;
      end
      stable_q   <= '0;
      edgeCap_q  <= '0;
      mask_q     <= '0;
      count_q    <= '0;
      readdata_q <= '0;
    end else begin
      debCnt_q   <= debCnt_d;
      stable_q   <= stable_d;
      edgeCap_q  <= edgeCap_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edgeCap_q & mask_q);

endmodule

// File: tb/tb_botoes_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_botoes_event_ctrl
// Self-checking bench for botoes_event_ctrl with WIDTH=4, DEBOUNCE_CYCLES=4,
// ACTIVE_LOW=1. A press therefore lands 6 clock edges after the pin changes.
// ---------------------------------------------------------------------------
module tb_botoes_event_ctrl;

  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} opKind_e;

  typedef struct {
    string       name;
    logic [3:0]  pins;
    int          waitTicks;
    logic        expIrq;
    opKind_e     op;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] expRead;
  } vector_t;

  typedef struct {
    string       name;
    logic [31:0] value;
  } expected_t;

  logic       clk;
  logic       reset_n;
  logic [3:0] inPort;
  logic       irq;

  int checkCount;
  int errorCount;

  vector_t   vecs[$];
  expected_t expQ[$];

  botoes_event_ctrl_if bus();

  botoes_event_ctrl #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .in_port(inPort),
    .irq(irq)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock edge and step away from it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pop the oldest expected read result and compare it with readdata.
  task automatic checkReadback();
    expected_t e;
    if (expQ.size() == 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL scoreboard: got readdata 0x%0h, expected an entry in queue", bus.readdata);
    end else begin
      e = expQ.pop_front();
      checkOutput(e.name, bus.readdata, e.value);
    end
  endtask

  // One bus cycle. Reads push their expected value and are checked after the
  // edge that registers readdata.
  task automatic applyStimulus(input opKind_e op, input logic [1:0] addr, input logic [31:0] data,
                               input logic [31:0] expRead, input string name);
    expected_t e;
    if (op == OP_WRITE) begin
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.address    = addr;
      bus.writedata  = data;
      tick();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
    end else if (op == OP_READ) begin
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      bus.address    = addr;
      e.name  = name;
      e.value = expRead;
      expQ.push_back(e);
      tick();
      bus.chipselect = 1'b0;
      checkReadback();
    end
  endtask

  function automatic void addVec(input string name, input logic [3:0] pins, input int waitTicks,
                                 input logic expIrq, input opKind_e op, input logic [1:0] addr,
                                 input logic [31:0] data, input logic [31:0] expRead);
    vector_t v;
    v.name      = name;
    v.pins      = pins;
    v.waitTicks = waitTicks;
    v.expIrq    = expIrq;
    v.op        = op;
    v.addr      = addr;
    v.data      = data;
    v.expRead   = expRead;
    vecs.push_back(v);
  endfunction

  task automatic pressRelease(input logic [3:0] pins);
    inPort = pins;
    repeat (6) tick();
    inPort = 4'hF;
    repeat (6) tick();
  endtask

  initial begin
    checkCount     = 0;
    errorCount     = 0;
    reset_n        = 1'b0;
    inPort         = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;

    // Press, read-back and W1C vectors; a press lands on the 6th edge.
    addVec("maskSet",        4'hF, 0, 1'b0, OP_WRITE, 2'd2, 32'h1, 32'h0);
    addVec("pressEarly",     4'hE, 5, 1'b0, OP_NONE,  2'd0, 32'h0, 32'h0);
    addVec("pressState",     4'hE, 1, 1'b1, OP_READ,  2'd0, 32'h0, 32'h1);
    addVec("pressEdge",      4'hE, 0, 1'b1, OP_READ,  2'd1, 32'h0, 32'h1);
    addVec("pressCount",     4'hE, 0, 1'b1, OP_READ,  2'd3, 32'h0, 32'h1);
    addVec("maskRead",       4'hE, 0, 1'b1, OP_READ,  2'd2, 32'h0, 32'h1);
    addVec("edgeW1c",        4'hE, 0, 1'b1, OP_WRITE, 2'd1, 32'h1, 32'h0);
    addVec("edgeCleared",    4'hE, 0, 1'b0, OP_READ,  2'd1, 32'h0, 32'h0);
    addVec("releaseEdge",    4'hF, 6, 1'b0, OP_READ,  2'd1, 32'h0, 32'h0);
    addVec("releaseState",   4'hF, 0, 1'b0, OP_READ,  2'd0, 32'h0, 32'h0);
    addVec("releaseCount",   4'hF, 0, 1'b0, OP_READ,  2'd3, 32'h0, 32'h1);
    addVec("stateWrite",     4'hF, 0, 1'b0, OP_WRITE, 2'd0, 32'hF, 32'h0);
    addVec("stateReadOnly",  4'hF, 0, 1'b0, OP_READ,  2'd0, 32'h0, 32'h0);

    // Reset state.
    repeat (3) tick();
    checkOutput("resetReaddata", bus.readdata, 32'h0);
    checkOutput("resetIrq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      applyStimulus(OP_READ, 2'(a), 32'h0, 32'h0, $sformatf("resetReg%0d", a));
    end

    // Table-driven vectors.
    foreach (vecs[k]) begin
      inPort = vecs[k].pins;
      repeat (vecs[k].waitTicks) tick();
      checkOutput({vecs[k].name, ".irq"}, {31'd0, irq}, {31'd0, vecs[k].expIrq});
      applyStimulus(vecs[k].op, vecs[k].addr, vecs[k].data, vecs[k].expRead, vecs[k].name);
    end

    // Glitch rejection: 3-cycle low pulses on key 2 never reach STATE.
    applyStimulus(OP_WRITE, 2'd3, 32'h0, 32'h0, "countClear");
    for (int g = 0; g < 5; g++) begin
      inPort = 4'hB;
      repeat (3) tick();
      inPort = 4'hF;
      repeat (3) tick();
    end
    repeat (6) tick();
    applyStimulus(OP_READ, 2'd0, 32'h0, 32'h0, "glitchState");
    applyStimulus(OP_READ, 2'd1, 32'h0, 32'h0, "glitchEdge");
    applyStimulus(OP_READ, 2'd3, 32'h0, 32'h0, "glitchCount");

    // Set-wins collision: W1C of bit 1 on the edge where key 1's press lands.
    applyStimulus(OP_WRITE, 2'd2, 32'h0, 32'h0, "maskZero");
    inPort = 4'hD;
    repeat (5) tick();
    applyStimulus(OP_WRITE, 2'd1, 32'h2, 32'h0, "collideW1c");
    checkOutput("collideIrqMasked", {31'd0, irq}, 32'h0);
    applyStimulus(OP_READ, 2'd1, 32'h0, 32'h2, "collideEdge");
    applyStimulus(OP_WRITE, 2'd2, 32'h2, 32'h0, "maskBit1");
    checkOutput("collideIrqUnmasked", {31'd0, irq}, 32'h1);
    applyStimulus(OP_WRITE, 2'd1, 32'hF, 32'h0, "edgeClearAll");
    checkOutput("collideIrqCleared", {31'd0, irq}, 32'h0);
    inPort = 4'hF;
    repeat (6) tick();

    // Count wrap: 256 presses bring COUNT back to 0, one more gives 1.
    applyStimulus(OP_WRITE, 2'd3, 32'h0, 32'h0, "countClear2");
    for (int n = 0; n < 256; n++) begin
      pressRelease(4'hE);
      if (n == 254) begin
        applyStimulus(OP_READ, 2'd3, 32'h0, 32'd255, "count255");
      end
    end
    applyStimulus(OP_READ, 2'd3, 32'h0, 32'h0, "countWrap");
    pressRelease(4'hE);
    applyStimulus(OP_READ, 2'd3, 32'h0, 32'h1, "countAfterWrap");

    // COUNT write on the same edge as a press leaves COUNT at 1.
    inPort = 4'hE;
    repeat (5) tick();
    applyStimulus(OP_WRITE, 2'd3, 32'h0, 32'h0, "countWriteCollide");
    inPort = 4'hF;
    repeat (6) tick();
    applyStimulus(OP_READ, 2'd3, 32'h0, 32'h1, "countCollide");

    // Keys 0 and 3 pressed together count once.
    applyStimulus(OP_WRITE, 2'd1, 32'hF, 32'h0, "edgeClearAll2");
    inPort = 4'h6;
    repeat (6) tick();
    applyStimulus(OP_READ, 2'd1, 32'h0, 32'h9, "dualEdge");
    applyStimulus(OP_READ, 2'd3, 32'h0, 32'h2, "dualCount");
    inPort = 4'hF;
    repeat (6) tick();

    // Reset mid-debounce aborts the count; the held key is re-detected after
    // reset lifts, exactly 6 edges later.
    applyStimulus(OP_WRITE, 2'd1, 32'hF, 32'h0, "edgeClearAll3");
    inPort = 4'hE;
    repeat (3) tick();
    reset_n = 1'b0;
    #2;
    checkOutput("midResetReaddata", bus.readdata, 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    applyStimulus(OP_WRITE, 2'd2, 32'h1, 32'h0, "maskAfterReset");
    repeat (4) tick();
    checkOutput("rearmIrqEarly", {31'd0, irq}, 32'h0);
    tick();
    checkOutput("rearmIrqOnTime", {31'd0, irq}, 32'h1);
    applyStimulus(OP_READ, 2'd3, 32'h0, 32'h1, "rearmCount");
    applyStimulus(OP_READ, 2'd1, 32'h0, 32'h1, "rearmEdge");

    // Asynchronous reset clears outputs without waiting for a clock edge.
    reset_n = 1'b0;
    #2;
    checkOutput("asyncIrq", {31'd0, irq}, 32'h0);
    checkOutput("asyncReaddata", bus.readdata, 32'h0);
    tick();
    reset_n = 1'b1;
    inPort  = 4'hF;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
